// File: rtl/e_mult_div_unit_pkg.sv
// Shared MDU definitions: op encodings, default latencies, FSM state type and
// the combinational multiply/divide helper used at issue time.
package mdu_pkg;

  localparam int MDU_OP_W        = 4;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [MDU_OP_W-1:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] hi;
    logic [31:0] lo;
  } mdu_result_t;

  // valid=0 marks a divide by zero: the op still runs its latency but never commits.
  function automatic mdu_result_t mdu_compute(input mdu_op_e op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
    mdu_result_t        res;
    logic               sgn;
    logic        [63:0] a64;
    logic        [63:0] b64;
    logic        [63:0] prod;
    logic signed [32:0] a33;
    logic signed [32:0] b33;
    logic        [31:0] quo;
    logic        [31:0] rem;
    res  = '0;
    sgn  = (op == MDU_MULT) || (op == MDU_DIV);
    a64  = {{32{a[31] & sgn}}, a};
    b64  = {{32{b[31] & sgn}}, b};
    a33  = {a[31] & sgn, a};
    b33  = {b[31] & sgn, b};
    prod = '0;
    quo  = '0;
    rem  = '0;
    case (op)
      MDU_MULT, MDU_MULTU: begin
        // Low 64 bits of a 64x64 product of extended operands are exact for both signednesses.
        prod      = a64 * b64;
        res.valid = 1'b1;
        res.hi    = prod[63:32];
        res.lo    = prod[31:0];
      end
      MDU_DIV, MDU_DIVU: begin
        if (b != 32'd0) begin
          quo       = 32'(a33 / b33);
          rem       = 32'(a33 % b33);
          res.valid = 1'b1;
          res.hi    = rem;
          res.lo    = quo;
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/e_mult_div_unit_if.sv
// Pipeline-to-MDU bundle. start is accepted only on a cycle with !req && !busy;
// any other cycle with start high has no effect and nothing is queued.
interface e_mult_div_unit_if;
  import mdu_pkg::*;

  logic                start;
  logic [MDU_OP_W-1:0] mdu_op;
  logic [31:0]         a;
  logic [31:0]         b;
  logic                req;
  logic                busy;
  logic [31:0]         hi;
  logic [31:0]         lo;
  logic [31:0]         rd_data;

  modport master (
    output start, mdu_op, a, b, req,
    input  busy, hi, lo, rd_data
  );

  modport slave (
    input  start, mdu_op, a, b, req,
    output busy, hi, lo, rd_data
  );

endinterface

// File: rtl/e_mult_div_unit.sv
// E-stage multiply/divide unit owning HI/LO. Results are computed at issue and
// held in temps until the latency counter expires, then committed together.
module e_mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  e_mult_div_unit_if.slave mdu,
  output mdu_state_e       dbg_state
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e  state;
  mdu_state_e  state_next;
  logic [CNT_W-1:0] cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  mdu_result_t tmp;
  mdu_result_t issue_res;
  mdu_op_e     op;
  logic        issue;
  logic        issue_mult;
  logic        issue_div;
  logic        last_cycle;

  assign op         = mdu_op_e'(mdu.mdu_op);
  assign issue      = mdu.start && !mdu.req && (state == ST_IDLE);
  assign issue_mult = issue && ((op == MDU_MULT) || (op == MDU_MULTU));
  assign issue_div  = issue && ((op == MDU_DIV)  || (op == MDU_DIVU));
  assign last_cycle = (state == ST_BUSY) && (cnt == CNT_W'(1));
  assign issue_res  = mdu_compute(op, mdu.a, mdu.b);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (issue_mult || issue_div) state_next = ST_BUSY;
      ST_BUSY: if (last_cycle)              state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mdu.busy    = (state == ST_BUSY);
    mdu.hi      = hi_q;
    mdu.lo      = lo_q;
    dbg_state   = state;
    mdu.rd_data = 32'd0;
    if (op == MDU_MFHI)      mdu.rd_data = hi_q;
    else if (op == MDU_MFLO) mdu.rd_data = lo_q;
  end

  // Datapath: counter, temps and architectural HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      hi_q <= '0;
      lo_q <= '0;
      tmp  <= '0;
    end else if (state == ST_IDLE) begin
      if (issue && (op == MDU_MTHI)) hi_q <= mdu.a;
      if (issue && (op == MDU_MTLO)) lo_q <= mdu.a;
      if (issue_mult) begin
        tmp <= issue_res;
        cnt <= CNT_W'(MULT_CYCLES);
      end else if (issue_div) begin
        tmp <= issue_res;
        cnt <= CNT_W'(DIV_CYCLES);
      end
    end else begin
      if (last_cycle) begin
        cnt <= '0;
        if (tmp.valid) begin
          hi_q <= tmp.hi;
          lo_q <= tmp.lo;
        end
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule
